// File: rtl/mem_arbiter.sv
// Round-robin req/ack arbiter sharing one fixed-latency memory
// between the CPU datapath port and the debug/loader port.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       pick_dbg;

  // Debug wins if alone, or on a tie when the CPU was granted last
  assign pick_dbg = dbg_req & (~cpu_req | ~last_grant);

  // Arbitration FSM; mem_* outputs double as the latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      cpu_rdata  <= 32'd0;
      dbg_rdata  <= 32'd0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req | dbg_req) begin
            grant_id   <= pick_dbg;
            last_grant <= pick_dbg;
            mem_we     <= pick_dbg ? dbg_we : cpu_we;
            mem_addr   <= pick_dbg ? dbg_addr : cpu_addr;
            mem_wdata  <= pick_dbg ? dbg_wdata : cpu_wdata;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
          if (cnt == 4'd1) begin
            if (!mem_we) begin
              if (grant_id) begin
                dbg_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            if (grant_id) begin
              dbg_ack <= 1'b1;
            end else begin
              cpu_ack <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at latency 1,
// one at latency 3, each with its own behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        c1_req, c1_we, c1_ack, d1_req, d1_we, d1_ack;
  logic [31:0] c1_addr, c1_wdata, c1_rdata;
  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic        m1_en, m1_we, busy1, gid1;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;

  logic        c3_req, c3_we, c3_ack, d3_req, d3_we, d3_ack;
  logic [31:0] c3_addr, c3_wdata, c3_rdata;
  logic [31:0] d3_addr, d3_wdata, d3_rdata;
  logic        m3_en, m3_we, busy3, gid3;
  logic [31:0] m3_addr, m3_wdata, m3_rdata;

  mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr),
    .cpu_wdata(c1_wdata), .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr),
    .dbg_wdata(d1_wdata), .dbg_rdata(d1_rdata), .dbg_ack(d1_ack),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
    .busy(busy1), .grant_id(gid1)
  );

  mem_arbiter #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
    .cpu_wdata(c3_wdata), .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr),
    .dbg_wdata(d3_wdata), .dbg_rdata(d3_rdata), .dbg_ack(d3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
    .busy(busy3), .grant_id(gid3)
  );

  // Memories: read data appears exactly LATENCY cycles after mem_en
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (m1_en && m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
    p1 <= m1_en ? mem1[m1_addr[7:0]] : 32'hxxxxxxxx;
    if (m3_en && m3_we) mem3[m3_addr[7:0]] <= m3_wdata;
    p3[0] <= m3_en ? mem3[m3_addr[7:0]] : 32'hxxxxxxxx;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign m1_rdata = p1;
  assign m3_rdata = p3[2];

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic pop1(input logic port, input logic [31:0] rd);
    exp_t e;
    tests++;
    assert (q1.size() != 0) else begin
      fails++;
      $error("FAIL sb1_spurious_ack: observed ack port %0d expected none",
             port);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("sb1_port", 32'(port), 32'(e.port));
      chk("sb1_rdata", rd, e.data);
    end
  endtask

  task automatic pop3(input logic port, input logic [31:0] rd);
    exp_t e;
    tests++;
    assert (q3.size() != 0) else begin
      fails++;
      $error("FAIL sb3_spurious_ack: observed ack port %0d expected none",
             port);
    end
    if (q3.size() != 0) begin
      e = q3.pop_front();
      chk("sb3_port", 32'(port), 32'(e.port));
      chk("sb3_rdata", rd, e.data);
    end
  endtask

  // Ack monitor: every ack pops the next expected completion
  always @(negedge clk) begin
    if (!reset) begin
      if (c1_ack) pop1(1'b0, c1_rdata);
      if (d1_ack) pop1(1'b1, d1_rdata);
      if (c3_ack) pop3(1'b0, c3_rdata);
      if (d3_ack) pop3(1'b1, d3_rdata);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the latency-1 instance, req from cycle 0
  task automatic txn1(input logic port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input bit hold);
    int   n;
    logic ack;
    q1.push_back('{port, exp_rd});
    if (port) begin
      d1_req = 1'b1; d1_we = we; d1_addr = addr; d1_wdata = wdata;
    end else begin
      c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wdata;
    end
    step;
    chk("txn_mem_en", 32'(m1_en), 32'd1);
    chk("txn_mem_addr", m1_addr, addr);
    chk("txn_mem_we", 32'(m1_we), 32'(we));
    chk("txn_mem_wdata", m1_wdata, wdata);
    chk("txn_grant", 32'(gid1), 32'(port));
    if (!hold) begin
      c1_req = 1'b0;
      d1_req = 1'b0;
    end
    n = 1;
    ack = 1'b0;
    while (!ack && n < 20) begin
      step;
      n++;
      ack = port ? d1_ack : c1_ack;
    end
    chk("txn_ack_cycle", 32'(n), 32'd3);
    c1_req = 1'b0;
    d1_req = 1'b0;
    step;
    chk("txn_idle_busy", 32'(busy1), 32'd0);
  endtask

  // CPU read of 0x10 on the latency-3 instance with cycle-exact checks
  task automatic rd3;
    q3.push_back('{1'b0, 32'hCAFE0010});
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h10;
    for (int k = 1; k <= 7; k++) begin
      step;
      chk($sformatf("l3_mem_en_k%0d", k), 32'(m3_en), 32'(k == 1));
      chk($sformatf("l3_busy_k%0d", k), 32'(busy3), 32'(k <= 5));
      chk($sformatf("l3_ack_k%0d", k), 32'(c3_ack), 32'(k == 5));
      if (k == 1) chk("l3_mem_addr", m3_addr, 32'h10);
      if (k == 5) c3_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    mem1[8'h10] = 32'hDEADBEEF;
    mem1[8'h11] = 32'hA5A50011;
    mem3[8'h10] = 32'hCAFE0010;
    mem3[8'h30] = 32'h0BAD0030;
    {c1_req, c1_we, d1_req, d1_we} = '0;
    {c3_req, c3_we, d3_req, d3_we} = '0;
    c1_addr = '0; c1_wdata = '0; d1_addr = '0; d1_wdata = '0;
    c3_addr = '0; c3_wdata = '0; d3_addr = '0; d3_wdata = '0;
    reset = 1'b1;
    step;
    step;
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_mem_en3", 32'(m3_en), 32'd0);
    chk("rst_rdata3", d3_rdata, 32'd0);
    reset = 1'b0;
    step;

    // Reset mid-ISSUE with cpu_req high clears everything at once
    c1_req = 1'b1; c1_addr = 32'h10;
    step;
    chk("pre_rst_mem_en", 32'(m1_en), 32'd1);
    chk("pre_rst_busy", 32'(busy1), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_en", 32'(m1_en), 32'd0);
    chk("async_busy", 32'(busy1), 32'd0);
    chk("async_mem_addr", m1_addr, 32'd0);
    chk("async_cpu_ack", 32'(c1_ack), 32'd0);
    chk("async_cpu_rdata", c1_rdata, 32'd0);
    c1_req = 1'b0;
    step;
    reset = 1'b0;
    step;

    // Tie from T0: CPU, debug, CPU, debug
    q1.push_back('{1'b0, 32'hDEADBEEF});
    q1.push_back('{1'b1, 32'hA5A50011});
    q1.push_back('{1'b0, 32'hDEADBEEF});
    q1.push_back('{1'b1, 32'hA5A50011});
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h10;
    d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'h11;
    for (int k = 1; k <= 16; k++) begin
      step;
      chk($sformatf("tie_mem_en_k%0d", k), 32'(m1_en),
          32'(k == 1 || k == 5 || k == 9 || k == 13));
      chk($sformatf("tie_cpu_ack_k%0d", k), 32'(c1_ack),
          32'(k == 3 || k == 11));
      chk($sformatf("tie_dbg_ack_k%0d", k), 32'(d1_ack),
          32'(k == 7 || k == 15));
      chk($sformatf("tie_grant_k%0d", k), 32'(gid1),
          32'(((k - 1) / 4) % 2));
      if (k == 11) c1_req = 1'b0;
      if (k == 15) d1_req = 1'b0;
    end
    chk("tie_end_busy", 32'(busy1), 32'd0);

    // Debug write then CPU readback; debug rdata untouched by write
    txn1(1'b1, 1'b1, 32'h20, 32'h12345678, 32'hA5A50011, 1'b1);
    txn1(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b1);
    chk("dbg_rdata_kept", d1_rdata, 32'hA5A50011);
    txn1(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    // Request withdrawn after one cycle still completes
    txn1(1'b1, 1'b0, 32'h11, 32'h0, 32'hA5A50011, 1'b0);

    // Latency 3
    rd3;

    // Reset in WAIT of a debug read aborts it without an ack
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h30;
    step;
    step;
    step;
    chk("abort_busy_pre", 32'(busy3), 32'd1);
    chk("abort_grant_pre", 32'(gid3), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_grant", 32'(gid3), 32'd0);
    d3_req = 1'b0;
    step;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step;
      chk($sformatf("abort_no_ack_%0d", k), 32'(d3_ack), 32'd0);
    end
    chk("abort_dbg_rdata", d3_rdata, 32'd0);
    rd3;
    chk("post_abort_grant", 32'(gid3), 32'd0);

    step;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
